// File: rtl/flash_cmd_sequencer_pkg.sv
// Shared encodings for the flash command sequencer: FSM states,
// JEDEC command bytes and last-command codes.
package flash_cmd_sequencer_pkg;

  // 3-bit state encoding; dbg_state exposes it unchanged.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_U1   = 3'd1,
    ST_U2   = 3'd2,
    ST_PROG = 3'd3,
    ST_E0   = 3'd4,
    ST_E1   = 3'd5,
    ST_E2   = 3'd6,
    ST_BUSY = 3'd7
  } state_t;

  localparam logic [7:0] CMD_AA = 8'hAA;
  localparam logic [7:0] CMD_55 = 8'h55;
  localparam logic [7:0] CMD_A0 = 8'hA0;
  localparam logic [7:0] CMD_80 = 8'h80;
  localparam logic [7:0] CMD_10 = 8'h10;
  localparam logic [7:0] CMD_30 = 8'h30;
  localparam logic [7:0] CMD_F0 = 8'hF0;

  localparam logic [1:0] LC_NONE = 2'd0;
  localparam logic [1:0] LC_PROG = 2'd1;
  localparam logic [1:0] LC_SECT = 2'd2;
  localparam logic [1:0] LC_CHIP = 2'd3;

endpackage

// File: rtl/flash_cmd_sequencer_timer.sv
// Busy window down-counter. Loads a length, counts down to zero and
// stops there; o_expire marks the last busy cycle (count == 1).
module flash_busy_timer #(
  parameter int CNT_W = 24
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_value,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;

  // Load takes priority; otherwise decrement without wrapping below zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = (r_count == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Flash command sequencer: follows JEDEC unlock/command sequences written
// to ROM space, lets only well-formed sequence writes reach the flash,
// and times the busy window after program/erase commands.
// Handshake: a write is cpu_wr && prg_write_enabled, single cycle, no
// back-pressure; flash_we_allow is a combinational qualifier for that
// same cycle's write and is never asserted without a write.
module flash_cmd_sequencer
  import flash_cmd_sequencer_pkg::*;
#(
  parameter logic [10:0]      ADDR_U1     = 11'h555,
  parameter logic [10:0]      ADDR_U2     = 11'h2AA,
  parameter int               CNT_W       = 24,
  parameter logic [CNT_W-1:0] PROG_CYCLES = 24'd40,
  parameter logic [CNT_W-1:0] SECT_CYCLES = 24'd400000,
  parameter logic [CNT_W-1:0] CHIP_CYCLES = 24'hFFFFFF
) (
  input  logic        m2,
  input  logic        reset,
  input  logic        prg_write_enabled,
  input  logic        cpu_wr,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  output logic        flash_we_allow,
  output logic        busy,
  output logic [1:0]  last_cmd,
  output logic        cmd_done,
  output logic        seq_error,
  output logic [2:0]  dbg_state
);

  state_t           r_state;
  state_t           w_next;
  logic             w_write;
  logic             w_at_u1;
  logic             w_at_u2;
  logic             w_err;
  logic             w_done;
  logic             w_load;
  logic [CNT_W-1:0] w_load_value;
  logic             w_cmd_set;
  logic [1:0]       w_cmd_val;
  logic             w_expire;

  assign w_write = cpu_wr & prg_write_enabled;
  assign w_at_u1 = (cpu_addr[10:0] == ADDR_U1);
  assign w_at_u2 = (cpu_addr[10:0] == ADDR_U2);

  flash_busy_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk        (m2),
    .i_reset      (reset),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .o_expire     (w_expire)
  );

  // Next-state, write gating and side effects of the command sequence.
  always_comb begin
    w_next         = r_state;
    flash_we_allow = 1'b0;
    w_err          = 1'b0;
    w_done         = 1'b0;
    w_load         = 1'b0;
    w_load_value   = '0;
    w_cmd_set      = 1'b0;
    w_cmd_val      = LC_NONE;
    if (r_state == ST_BUSY) begin
      // Writes during the operation are dropped and flagged, even on the last cycle.
      if (w_write) w_err = 1'b1;
      if (w_expire) begin
        w_next = ST_IDLE;
        w_done = 1'b1;
      end
    end else if (w_write) begin
      flash_we_allow = 1'b1;
      w_next         = ST_IDLE;
      case (r_state)
        ST_IDLE: begin
          if (cpu_data == CMD_AA && w_at_u1) w_next = ST_U1;
          else if (cpu_data != CMD_F0) flash_we_allow = 1'b0;
        end
        ST_U1: begin
          if (cpu_data == CMD_55 && w_at_u2) w_next = ST_U2;
          else flash_we_allow = 1'b0;
        end
        ST_U2: begin
          if (cpu_data == CMD_A0 && w_at_u1) w_next = ST_PROG;
          else if (cpu_data == CMD_80 && w_at_u1) w_next = ST_E0;
          else if (cpu_data != CMD_F0) flash_we_allow = 1'b0;
        end
        ST_PROG: begin
          w_next       = ST_BUSY;
          w_load       = 1'b1;
          w_load_value = PROG_CYCLES;
          w_cmd_set    = 1'b1;
          w_cmd_val    = LC_PROG;
        end
        ST_E0: begin
          if (cpu_data == CMD_AA && w_at_u1) w_next = ST_E1;
          else flash_we_allow = 1'b0;
        end
        ST_E1: begin
          if (cpu_data == CMD_55 && w_at_u2) w_next = ST_E2;
          else flash_we_allow = 1'b0;
        end
        ST_E2: begin
          if (cpu_data == CMD_10 && w_at_u1) begin
            w_next       = ST_BUSY;
            w_load       = 1'b1;
            w_load_value = CHIP_CYCLES;
            w_cmd_set    = 1'b1;
            w_cmd_val    = LC_CHIP;
          end else if (cpu_data == CMD_30) begin
            w_next       = ST_BUSY;
            w_load       = 1'b1;
            w_load_value = SECT_CYCLES;
            w_cmd_set    = 1'b1;
            w_cmd_val    = LC_SECT;
          end else begin
            flash_we_allow = 1'b0;
          end
        end
        default: flash_we_allow = 1'b0;
      endcase
      // Any write that was not a legal step breaks the sequence.
      if (!flash_we_allow) w_err = 1'b1;
    end
  end

  // State and registered status outputs.
  always_ff @(posedge m2) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      last_cmd  <= LC_NONE;
      cmd_done  <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      r_state   <= w_next;
      cmd_done  <= w_done;
      seq_error <= seq_error | w_err;
      if (w_cmd_set) last_cmd <= w_cmd_val;
    end
  end

  assign busy      = (r_state == ST_BUSY);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Bench for flash_cmd_sequencer: directed scenarios followed by random
// command scripts, all compared against a sequence-prefix reference model.
module tb_flash_cmd_sequencer;

  localparam logic [23:0] P_PROG = 24'd40;
  localparam logic [23:0] P_SECT = 24'd300;
  localparam logic [23:0] P_CHIP = 24'd500;

  // ---------------- clock / reset / DUT ----------------
  logic        m2 = 1'b0;
  logic        reset = 1'b1;
  logic        prg_write_enabled = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        flash_we_allow;
  logic        busy;
  logic [1:0]  last_cmd;
  logic        cmd_done;
  logic        seq_error;
  logic [2:0]  dbg_state;

  always #5 m2 = ~m2;

  flash_cmd_sequencer #(
    .PROG_CYCLES (P_PROG),
    .SECT_CYCLES (P_SECT),
    .CHIP_CYCLES (P_CHIP)
  ) dut (
    .m2                (m2),
    .reset             (reset),
    .prg_write_enabled (prg_write_enabled),
    .cpu_wr            (cpu_wr),
    .cpu_addr          (cpu_addr),
    .cpu_data          (cpu_data),
    .flash_we_allow    (flash_we_allow),
    .busy              (busy),
    .last_cmd          (last_cmd),
    .cmd_done          (cmd_done),
    .seq_error         (seq_error),
    .dbg_state         (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  int busy_seen = 0;

  // ---------------- reference model ----------------
  // m_len: how many writes of the current command sequence were accepted.
  int       m_len = 0;
  bit       m_erase = 0;
  int       m_busy_left = 0;
  bit [1:0] m_last = 0;
  bit       m_done = 0;
  bit       m_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Is (a,d) an acceptable next write after 'len' accepted sequence writes?
  // Program: AA@555 55@2AA A0@555 <any>
  // Erase:   AA@555 55@2AA 80@555 AA@555 55@2AA (10@555 | 30@any)
  // F0@any is accepted as a reset before the sequence or after the unlock pair.
  function automatic bit model_legal(input int len, input bit erase,
                                     input logic [14:0] a, input logic [7:0] d);
    logic [10:0] lo;
    lo = a[10:0];
    case (len)
      0: return (d == 8'hAA && lo == 11'h555) || d == 8'hF0;
      1: return d == 8'h55 && lo == 11'h2AA;
      2: return ((d == 8'hA0 || d == 8'h80) && lo == 11'h555) || d == 8'hF0;
      3: return erase ? (d == 8'hAA && lo == 11'h555) : 1'b1;
      4: return d == 8'h55 && lo == 11'h2AA;
      5: return (d == 8'h10 && lo == 11'h555) || d == 8'h30;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver: one bus cycle with checks ----------------
  task automatic cycle(input bit rst, input bit wr, input bit en,
                       input logic [14:0] a, input logic [7:0] d);
    bit w;
    bit legal;
    @(negedge m2);
    reset = rst; cpu_wr = wr; prg_write_enabled = en; cpu_addr = a; cpu_data = d;
    w = wr && en;
    legal = w && (m_busy_left == 0) && model_legal(m_len, m_erase, a, d);
    #1;
    if (!rst) check("allow", flash_we_allow, legal);
    m_done = 0;
    if (rst) begin
      m_len = 0; m_erase = 0; m_busy_left = 0; m_last = 0; m_err = 0;
    end else if (m_busy_left > 0) begin
      if (w) m_err = 1;
      if (m_busy_left == 1) m_done = 1;
      m_busy_left--;
    end else if (w) begin
      if (!legal) begin
        m_len = 0; m_erase = 0; m_err = 1;
      end else if (d == 8'hF0 && (m_len == 0 || m_len == 2)) begin
        m_len = 0;
      end else begin
        if (m_len == 2) m_erase = (d == 8'h80);
        if (m_len == 3 && !m_erase) begin
          m_busy_left = P_PROG; m_last = 1; m_len = 0;
        end else if (m_len == 5) begin
          if (d == 8'h10) begin m_busy_left = P_CHIP; m_last = 3; end
          else begin m_busy_left = P_SECT; m_last = 2; end
          m_len = 0; m_erase = 0;
        end else begin
          m_len++;
        end
      end
    end
    @(posedge m2);
    #1;
    check("busy", busy, m_busy_left > 0);
    check("cmd_done", cmd_done, m_done);
    check("last_cmd", last_cmd, m_last);
    check("seq_error", seq_error, m_err);
    check("idle", dbg_state == 3'd0, m_len == 0 && m_busy_left == 0);
    if (busy) busy_seen++;
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d);
    cycle(0, 1, 1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(0, 0, 1, 15'($urandom), 8'($urandom));
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, '0, '0);
  endtask

  task automatic program_seq(input logic [14:0] a, input logic [7:0] d);
    wr(15'h0555, 8'hAA); wr(15'h02AA, 8'h55); wr(15'h0555, 8'hA0); wr(a, d);
  endtask

  task automatic erase_prefix();
    wr(15'h0555, 8'hAA); wr(15'h02AA, 8'h55); wr(15'h0555, 8'h80);
    wr(15'h0555, 8'hAA); wr(15'h02AA, 8'h55);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [14:0] sa[6];
    logic [7:0]  sd[6];
    int n;
    int kind;

    // reset state
    do_reset(); do_reset();
    check("reset_busy", busy, 0);
    check("reset_last", last_cmd, 0);

    // byte program, busy exactly PROG cycles
    busy_seen = 0;
    program_seq(15'h1234, 8'h3C);
    idle(45);
    check("prog_busy_len", busy_seen, P_PROG);

    // sector erase
    busy_seen = 0;
    erase_prefix();
    wr(15'h4000, 8'h30);
    idle(305);
    check("sect_busy_len", busy_seen, P_SECT);

    // broken sequence, then a valid program
    wr(15'h0555, 8'hAA); wr(15'h02AA, 8'h56);
    busy_seen = 0;
    program_seq(15'h7FFF, 8'hF0);
    idle(45);
    check("prog_after_break_len", busy_seen, P_PROG);

    // write during busy leaves the busy length intact
    do_reset();
    busy_seen = 0;
    program_seq(15'h0100, 8'h5A);
    idle(5);
    wr(15'h0000, 8'h12);
    idle(40);
    check("busy_len_with_write", busy_seen, P_PROG);

    // write on the last busy cycle
    do_reset();
    program_seq(15'h0100, 8'h01);
    idle(P_PROG - 1);
    wr(15'h0555, 8'hAA);
    idle(2);

    // flash writes disabled
    do_reset();
    cycle(0, 1, 0, 15'h0555, 8'hAA);
    wr(15'h0555, 8'hF0);

    // F0 after the unlock pair, F0 illegal after U1
    wr(15'h0555, 8'hAA); wr(15'h02AA, 8'h55); wr(15'h3333, 8'hF0);
    wr(15'h0555, 8'hAA); wr(15'h0123, 8'hF0);

    // chip erase with upper address bits set
    do_reset();
    busy_seen = 0;
    erase_prefix();
    wr(15'h7D55, 8'h10);
    idle(505);
    check("chip_busy_len", busy_seen, P_CHIP);

    // reset in the middle of a program busy window
    program_seq(15'h0042, 8'h99);
    idle(9);
    do_reset();
    idle(5);

    // random command scripts
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 4) == 0) do_reset();
      kind = $urandom_range(0, 3);
      sa[0] = {4'($urandom), 11'h555}; sd[0] = 8'hAA;
      sa[1] = {4'($urandom), 11'h2AA}; sd[1] = 8'h55;
      sa[2] = {4'($urandom), 11'h555}; sd[2] = (kind == 0) ? 8'hA0 : 8'h80;
      sa[3] = {4'($urandom), 11'h555}; sd[3] = 8'hAA;
      sa[4] = {4'($urandom), 11'h2AA}; sd[4] = 8'h55;
      sa[5] = 15'($urandom);           sd[5] = 8'h30;
      case (kind)
        0: begin n = 4; sa[3] = 15'($urandom); sd[3] = 8'($urandom); end
        1: n = 6;
        2: begin n = 6; sa[5] = {4'($urandom), 11'h555}; sd[5] = 8'h10; end
        default: begin n = 3; sa[2] = 15'($urandom); sd[2] = 8'hF0; end
      endcase
      if ($urandom_range(0, 3) == 0) begin
        int idx;
        idx = $urandom_range(0, n - 1);
        sd[idx] = sd[idx] ^ 8'($urandom_range(1, 255));
      end
      for (int i = 0; i < n; i++) begin
        cycle(0, 1, $urandom_range(0, 9) != 0, sa[i], sd[i]);
        idle($urandom_range(0, 2));
      end
      for (int i = 0; i < 600 && m_busy_left != 0; i++) idle(1);
      idle(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
